// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encoding, error codes and default timing at 97.5 MHz.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_RTS        = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_SHIFT      = 3'd4,
        ST_ACK        = 3'd5,
        ST_WAIT_IDLE  = 3'd6
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE           = 2'b00;
    localparam logic [1:0] ERR_START_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_PACKET_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NO_ACK         = 2'b11;

    localparam int PS2_INHIBIT_CYCLES = 11700;
    localparam int PS2_START_TIMEOUT  = 1462500;
    localparam int PS2_PACKET_TIMEOUT = 195000;
    localparam int PS2_CNT_W          = 21;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin plus a falling-edge strobe.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data via registered OEs.
// Handshake: a byte is taken on any cycle where tx_valid & tx_ready; tx_valid while busy is dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int PACKET_TIMEOUT = PS2_PACKET_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output ps2_state_e dbg_state
);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_CNT_W-1:0] START_LAST   = PS2_CNT_W'(START_TIMEOUT - 1);
    localparam logic [PS2_CNT_W-1:0] PACKET_LAST  = PS2_CNT_W'(PACKET_TIMEOUT - 1);

    ps2_state_e           state_q, state_d;
    logic [PS2_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic                 ack_q, ack_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic clk_sync;
    logic clk_fall;
    logic data_meta_q;
    logic data_sync_q;
    logic accept;
    logic start_to;
    logic packet_to;
    logic abort;
    logic [1:0] abort_code;

    ps2_sync_edge u_clk_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .pin_i  (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // Ready stays low through the done/err pulse so it rises the cycle after.
    assign tx_ready  = (state_q == ST_IDLE) & ~done_q & ~err_q;
    assign busy      = ~tx_ready;
    assign accept    = tx_valid & tx_ready;
    assign start_to  = (cnt_q >= START_LAST);
    assign packet_to = (cnt_q >= PACKET_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        shreg_d    = shreg_q;
        par_d      = par_q;
        bitcnt_d   = bitcnt_q;
        ack_d      = ack_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    state_d    = ST_INHIBIT;
                    shreg_d    = tx_data;
                    par_d      = ~^tx_data;
                    err_code_d = ERR_NONE;
                    cnt_d      = '0;
                    clk_oe_d   = 1'b1;
                    data_oe_d  = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q >= INHIBIT_LAST) begin
                    state_d   = ST_RTS;
                    data_oe_d = 1'b1;
                end
            end
            ST_RTS: begin
                state_d  = ST_WAIT_START;
                clk_oe_d = 1'b0;
                cnt_d    = '0;
            end
            ST_WAIT_START: begin
                // Timeout is checked first so it wins over a coincident edge.
                if (start_to) begin
                    abort      = 1'b1;
                    abort_code = ERR_START_TIMEOUT;
                end else if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    bitcnt_d  = 4'd1;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (packet_to) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET_TIMEOUT;
                end else if (clk_fall) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    case (bitcnt_q)
                        4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7: data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                        4'd8:             data_oe_d = ~par_q;
                        4'd9:             data_oe_d = 1'b0;
                        default: begin
                            ack_d   = data_sync_q;
                            state_d = ST_ACK;
                        end
                    endcase
                end
            end
            ST_ACK: begin
                if (packet_to) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET_TIMEOUT;
                end else if (ack_q) begin
                    abort      = 1'b1;
                    abort_code = ERR_NO_ACK;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (packet_to) begin
                    abort      = 1'b1;
                    abort_code = ERR_PACKET_TIMEOUT;
                end else if (clk_sync && data_sync_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = abort_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bitcnt_q   <= '0;
            ack_q      <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bitcnt_q   <= bitcnt_d;
            ack_q      <= ack_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; bits are scored against a byte-level model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH      = 20;
    localparam int START_TO = 3000;
    localparam int PKT_TO   = 4000;
    localparam int HALF     = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    ps2_state_e dbg_state;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_line;
    logic data_line;
    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int clk_hi_cnt = 0;
    int rts_cnt = 0;
    int ws_cnt = 0;

    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START_TO),
        .PACKET_TIMEOUT (PKT_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (ps2_clk_oe) clk_hi_cnt++;
        if (ps2_clk_oe && ps2_data_oe) rts_cnt++;
        if (ps2_data_oe && !ps2_clk_oe && !tx_ready) ws_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    task automatic expect_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        exp_q.push_back(1'b1);
    endtask

    task automatic compare_frame(input string tag);
        logic [0:0] o;
        logic [0:0] e;
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_bit"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n;
        n = 0;
        while (!tx_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, tx_ready, 1);
    endtask

    // Device model: clocks the frame, samples data before each rising edge, optional ack.
    task automatic device_frame(input bit acks, input int abort_bit, input int stop_after);
        int n;
        n = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", ps2_data_oe && !ps2_clk_oe, 1);
        if (!(ps2_data_oe && !ps2_clk_oe)) return;
        repeat (HALF) @(negedge clk);
        obs_q.push_back(data_line);
        for (int i = 0; i < 10; i++) begin
            if (i == stop_after) return;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i == abort_bit) begin
                #3;
                rst = 1'b0;
                #1;
                check("rst_clk_oe", ps2_clk_oe, 0);
                check("rst_data_oe", ps2_data_oe, 0);
                check("rst_ready", tx_ready, 1);
                dev_clk = 1'b1;
                return;
            end
            obs_q.push_back(data_line);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (acks) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_ok(input logic [7:0] b, input bit poke_busy);
        int d0, e0, c0, r0;
        d0 = done_cnt;
        e0 = err_cnt;
        c0 = clk_hi_cnt;
        r0 = rts_cnt;
        expect_frame(b);
        send_byte(b);
        if (poke_busy) begin
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        device_frame(1'b1, -1, -1);
        wait_ready(PKT_TO, "ok");
        compare_frame("frame");
        repeat (40) @(negedge clk);
        check("ok_done_pulses", done_cnt - d0, 1);
        check("ok_err_pulses", err_cnt - e0, 0);
        check("ok_err_code", err_code, ERR_NONE);
        check("inhibit_cycles", clk_hi_cnt - c0, INH + 1);
        check("rts_overlap", rts_cnt - r0, 1);
        check("ok_idle_after", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    endtask

    initial begin
        int d0, e0, w0;
        logic [7:0] b;

        // Reset.
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}, 6'b100000);
        check("reset_err_code", err_code, ERR_NONE);
        check("reset_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ready", tx_ready, 1);

        // Canonical 0xF4, then random bytes.
        run_ok(8'hF4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            run_ok(b, 1'b0);
        end

        // 0xAA offered while busy must be dropped.
        run_ok(8'hF4, 1'b1);

        // No device clock: start timeout.
        d0 = done_cnt;
        e0 = err_cnt;
        w0 = ws_cnt;
        send_byte(8'($urandom_range(0, 255)));
        wait_ready(START_TO + INH + 100, "start_to");
        check("start_to_cycles", ws_cnt - w0, START_TO);
        check("start_to_code", err_code, ERR_START_TIMEOUT);
        check("start_to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("start_to_err_pulses", err_cnt - e0, 1);
        check("start_to_done_pulses", done_cnt - d0, 0);

        // Device never acks.
        d0 = done_cnt;
        e0 = err_cnt;
        b = 8'($urandom_range(0, 255));
        expect_frame(b);
        send_byte(b);
        device_frame(1'b0, -1, -1);
        wait_ready(PKT_TO, "noack");
        compare_frame("noack_frame");
        check("noack_code", err_code, ERR_NO_ACK);
        check("noack_done_pulses", done_cnt - d0, 0);
        check("noack_err_pulses", err_cnt - e0, 1);

        // Device stalls mid-frame: packet timeout.
        e0 = err_cnt;
        send_byte(8'h5A);
        device_frame(1'b1, -1, 3);
        wait_ready(PKT_TO + 500, "pkt_to");
        obs_q.delete();
        check("pkt_to_code", err_code, ERR_PACKET_TIMEOUT);
        check("pkt_to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("pkt_to_err_pulses", err_cnt - e0, 1);

        // Reset during bit 4, then a fresh transfer.
        send_byte(8'hF4);
        device_frame(1'b1, 4, -1);
        obs_q.delete();
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("in_reset_code", err_code, ERR_NONE);
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_ready", tx_ready, 1);
        run_ok(8'hF4, 1'b0);

        check("done_err_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
